// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle processor. It steps each instruction through
// fetch, decode, execute, memory and writeback, and drives datapath selects, enables and the ALU function code.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       irwrite_raw, regwrite_raw, memwrite_raw, pcwrite, branch;

    function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [5:0] fn);
        logic [2:0] f;
        f = 3'b010;
        if (aop == 2'b01) begin
            f = 3'b110;
        end else if (aop == 2'b10) begin
            case (fn)
                6'b100000: f = 3'b010;
                6'b100010: f = 3'b110;
                6'b100100: f = 3'b000;
                6'b100101: f = 3'b001;
                6'b101010: f = 3'b111;
                6'b011000: f = 3'b011;
                default:   f = 3'b010;
            endcase
        end
        return f;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = FETCH;
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = 2'b00;
        case (state_q)
            FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = mem_ready;
                pcwrite     = mem_ready;
                state_d     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                aluop        = 2'b10;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: regwrite_raw = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables are held off for the whole reset interval, not just until the state settles.
    assign alucontrol = alu_decode(aluop, funct);
    assign irwrite    = irwrite_raw & rst_n;
    assign regwrite   = regwrite_raw & rst_n;
    assign memwrite   = memwrite_raw & rst_n;
    assign pcen       = (pcwrite | (branch & zero)) & rst_n;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: the driver queues the expected
// output word for each cycle, and a negedge monitor pops and compares it.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen)
    );

    logic [14:0] act;
    assign act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, alucontrol, pcsrc, pcen};

    logic [14:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [5:0]  cur_op = 6'd0;
    logic [5:0]  cur_funct = 6'd0;

    function automatic logic [14:0] ev(input logic io, mw, irw, rd, m2r, rw, asa,
                                       input logic [1:0] asb, input logic [2:0] alu,
                                       input logic [1:0] ps, input logic pe);
        return {io, mw, irw, rd, m2r, rw, asa, asb, alu, ps, pe};
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            6'b011000: return 3'b011;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [14:0] idle_fetch();
        return ev(0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
    endfunction

    task automatic cycle(input logic mr, input logic z, input logic [14:0] e);
        @(posedge clk);
        #1;
        op = cur_op;
        funct = cur_funct;
        mem_ready = mr;
        zero = z;
        exp_q.push_back(e);
    endtask

    task automatic do_instr(input logic [5:0] o, input logic [5:0] f,
                            input int wf, input int wm, input logic zb);
        logic [14:0] memadr_e, memrd_e;
        memadr_e = ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
        memrd_e  = ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0);
        cur_op = o;
        cur_funct = f;
        repeat (wf) cycle(1'b0, rb(), idle_fetch());
        cycle(1'b1, rb(), ev(0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1));
        cycle(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0));
        case (o)
            6'b100011: begin
                cycle(rb(), rb(), memadr_e);
                repeat (wm) cycle(1'b0, rb(), memrd_e);
                cycle(1'b1, rb(), memrd_e);
                cycle(rb(), rb(), ev(0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0));
            end
            6'b101011: begin
                cycle(rb(), rb(), memadr_e);
                cycle(rb(), rb(), ev(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0));
            end
            6'b000000: begin
                cycle(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 1, 2'b00, rtype_alu(f), 2'b00, 0));
                cycle(rb(), rb(), ev(0, 0, 0, 1, 0, 1, 0, 2'b00, rtype_alu(f), 2'b00, 0));
            end
            6'b000100: cycle(rb(), zb, ev(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, zb));
            6'b001000: begin
                cycle(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
                cycle(rb(), rb(), ev(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0));
            end
            6'b000010: cycle(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 1));
            default: ;
        endcase
    endtask

    initial begin : monitor
        logic [14:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        logic [5:0] ops[6];
        logic [5:0] functs[6];
        logic [5:0] o, f;
        ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};

        // reset held with mem_ready high: enables forced low, FETCH values shown
        repeat (3) cycle(1'b1, 1'b0, idle_fetch());
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;

        do_instr(6'b100011, 6'd0, 0, 2, 1'b0);
        do_instr(6'b000000, 6'b100010, 0, 0, 1'b0);
        do_instr(6'b000000, 6'b011000, 1, 0, 1'b0);
        do_instr(6'b000000, 6'b111111, 0, 0, 1'b0);
        do_instr(6'b000100, 6'd5, 0, 0, 1'b1);
        do_instr(6'b000100, 6'd5, 0, 0, 1'b0);
        do_instr(6'b101011, 6'd9, 2, 0, 1'b0);
        do_instr(6'b111111, 6'd0, 0, 0, 1'b0);
        do_instr(6'b001000, 6'd0, 0, 0, 1'b0);
        do_instr(6'b000010, 6'd0, 0, 0, 1'b0);

        // lw abandoned by reset asserted during MEMADR
        cur_op = 6'b100011;
        cur_funct = 6'd0;
        cycle(1'b1, 1'b0, ev(0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1));
        cycle(1'b1, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0));
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        zero = 1'b0;
        #1;
        rst_n = 1'b0;
        exp_q.push_back(idle_fetch());
        cycle(1'b1, 1'b0, idle_fetch());
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;

        repeat (80) begin
            int k;
            k = $urandom_range(0, 6);
            if (k < 6) begin
                o = ops[k];
            end else begin
                o = 6'($urandom);
                while (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                       o == 6'b000100 || o == 6'b001000 || o == 6'b000010)
                    o = 6'($urandom);
            end
            f = rb() ? functs[$urandom_range(0, 5)] : 6'($urandom);
            do_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
